sram_1p_march_bist: RTL

SRAM_1P_MARCH_BIST -- requirements
Module: sram_1p_march_bist

---
 rtl/sram_bist_pkg.sv | 51 +++++
 rtl/sram_1p_array.sv | 28 ++
 rtl/sram_1p_march_bist.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sram_bist_pkg.sv
// Shared types for the single-port SRAM with built-in March C- self-test:
// engine states and the per-element operation table.
package sram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        M0_W0_UP,
        M1_R0W1_UP,
        M2_R1W0_UP,
        M3_R0W1_DN,
        M4_R1W0_DN,
        M5_R0_UP,
        FLUSH
    } bist_state_t;

    typedef struct packed {
        logic rd;
        logic wr;
        logic up;
        logic rd_bg;
        logic wr_bg;
    } march_elem_t;

    // Indexed by bist_state_t; IDLE and FLUSH issue no array operations.
    localparam march_elem_t ELEM_TABLE [8] = '{
        '{rd: 1'b0, wr: 1'b0, up: 1'b1, rd_bg: 1'b0, wr_bg: 1'b0},
        '{rd: 1'b0, wr: 1'b1, up: 1'b1, rd_bg: 1'b0, wr_bg: 1'b0},
        '{rd: 1'b1, wr: 1'b1, up: 1'b1, rd_bg: 1'b0, wr_bg: 1'b1},
        '{rd: 1'b1, wr: 1'b1, up: 1'b1, rd_bg: 1'b1, wr_bg: 1'b0},
        '{rd: 1'b1, wr: 1'b1, up: 1'b0, rd_bg: 1'b0, wr_bg: 1'b1},
        '{rd: 1'b1, wr: 1'b1, up: 1'b0, rd_bg: 1'b1, wr_bg: 1'b0},
        '{rd: 1'b1, wr: 1'b0, up: 1'b1, rd_bg: 1'b0, wr_bg: 1'b0},
        '{rd: 1'b0, wr: 1'b0, up: 1'b1, rd_bg: 1'b0, wr_bg: 1'b0}
    };

    function automatic bist_state_t next_elem(input bist_state_t s);
        bist_state_t n;
        n = IDLE;
        case (s)
            M0_W0_UP:   n = M1_R0W1_UP;
            M1_R0W1_UP: n = M2_R1W0_UP;
            M2_R1W0_UP: n = M3_R0W1_DN;
            M3_R0W1_DN: n = M4_R1W0_DN;
            M4_R1W0_DN: n = M5_R0_UP;
            M5_R0_UP:   n = FLUSH;
            default:    n = IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sram_1p_array.sv
// Single-port word array with per-bit write mask and registered read data.
// Storage has no reset; read data only changes on a read cycle.
module sram_1p_array #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_ADDR_WIDTH = 13
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [P_ADDR_WIDTH-1:0] addr,
    input  logic [P_DATA_WIDTH-1:0] din,
    input  logic [P_DATA_WIDTH-1:0] bm,
    output logic [P_DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** P_ADDR_WIDTH;

    logic [DEPTH-1:0][P_DATA_WIDTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= (mem[addr] & ~bm) | (din & bm);
        end else if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sram_1p_march_bist.sv
// Single-port SRAM wrapper with a March C- self-test engine that takes over
// the array port while busy and reports the first failing address.
module sram_1p_march_bist
    import sram_bist_pkg::*;
#(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_ADDR_WIDTH = 13
) (
    input  logic                    A_CLK,
    input  logic                    A_RST,
    input  logic                    A_MEN,
    input  logic                    A_WEN,
    input  logic                    A_REN,
    input  logic [P_ADDR_WIDTH-1:0] A_ADDR,
    input  logic [P_DATA_WIDTH-1:0] A_DIN,
    input  logic [P_DATA_WIDTH-1:0] A_BM,
    output logic [P_DATA_WIDTH-1:0] A_DOUT,
    input  logic                    A_BIST_START,
    output logic                    A_BIST_BUSY,
    output logic                    A_BIST_DONE,
    output logic                    A_BIST_FAIL,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_FAIL_ADDR
);

    localparam logic [P_ADDR_WIDTH-1:0] ADDR_MAX = '1;

    bist_state_t               state;
    bist_state_t               nxt_state;
    march_elem_t               elem;
    logic [P_ADDR_WIDTH-1:0]   addr_cnt;
    logic [P_ADDR_WIDTH-1:0]   nxt_start_addr;
    logic                      phase;
    logic                      cmp_valid;
    logic                      cmp_exp_bit;
    logic [P_ADDR_WIDTH-1:0]   cmp_addr;
    logic                      busy;
    logic                      done;
    logic                      fail;
    logic [P_ADDR_WIDTH-1:0]   fail_addr;
    logic [P_DATA_WIDTH-1:0]   dout_hold;
    logic                      dout_live;

    logic                      bist_rd;
    logic                      bist_wr;
    logic                      last_addr;
    logic                      start_ok;
    logic                      func_acc;
    logic                      func_rd;
    logic                      mismatch;

    logic                      arr_en;
    logic                      arr_we;
    logic [P_ADDR_WIDTH-1:0]   arr_addr;
    logic [P_DATA_WIDTH-1:0]   arr_din;
    logic [P_DATA_WIDTH-1:0]   arr_bm;
    logic [P_DATA_WIDTH-1:0]   arr_rdata;

    // phase=0 is the read slot, phase=1 the write slot of a read-then-write element.
    always_comb begin
        elem           = ELEM_TABLE[state];
        nxt_state      = next_elem(state);
        nxt_start_addr = ELEM_TABLE[nxt_state].up ? '0 : ADDR_MAX;
        bist_rd        = busy && elem.rd && !phase;
        bist_wr        = busy && elem.wr && (phase || !elem.rd);
        last_addr      = elem.up ? (addr_cnt == ADDR_MAX) : (addr_cnt == '0);
        start_ok       = (state == IDLE) && A_BIST_START;
        func_acc       = (state == IDLE) && !A_BIST_START && A_MEN && (A_WEN || A_REN);
        func_rd        = func_acc && !A_WEN;
        mismatch       = cmp_valid && (arr_rdata != {P_DATA_WIDTH{cmp_exp_bit}});

        if (busy) begin
            arr_en   = bist_rd || bist_wr;
            arr_we   = bist_wr;
            arr_addr = addr_cnt;
            arr_din  = {P_DATA_WIDTH{elem.wr_bg}};
            arr_bm   = '1;
        end else begin
            arr_en   = func_acc;
            arr_we   = A_WEN;
            arr_addr = A_ADDR;
            arr_din  = A_DIN;
            arr_bm   = A_BM;
        end
    end

    sram_1p_array #(
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_ADDR_WIDTH (P_ADDR_WIDTH)
    ) u_array (
        .clk   (A_CLK),
        .en    (arr_en),
        .we    (arr_we),
        .addr  (arr_addr),
        .din   (arr_din),
        .bm    (arr_bm),
        .rdata (arr_rdata)
    );

    // The array read register is shared with the engine, so the last functional
    // read value is parked in dout_hold for the duration of a test.
    assign A_DOUT           = dout_live ? arr_rdata : dout_hold;
    assign A_BIST_BUSY      = busy;
    assign A_BIST_DONE      = done;
    assign A_BIST_FAIL      = fail;
    assign A_BIST_FAIL_ADDR = fail_addr;

    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            state       <= IDLE;
            addr_cnt    <= '0;
            phase       <= 1'b0;
            cmp_valid   <= 1'b0;
            cmp_exp_bit <= 1'b0;
            cmp_addr    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            fail_addr   <= '0;
            dout_hold   <= '0;
            dout_live   <= 1'b0;
        end else begin
            cmp_valid   <= bist_rd;
            cmp_exp_bit <= elem.rd_bg;
            cmp_addr    <= addr_cnt;

            if (mismatch && !fail) begin
                fail      <= 1'b1;
                fail_addr <= cmp_addr;
            end

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state     <= M0_W0_UP;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        fail      <= 1'b0;
                        fail_addr <= '0;
                        addr_cnt  <= '0;
                        phase     <= 1'b0;
                        dout_hold <= A_DOUT;
                        dout_live <= 1'b0;
                    end else if (func_rd) begin
                        dout_live <= 1'b1;
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    if (elem.rd && elem.wr && !phase) begin
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (last_addr) begin
                            state    <= nxt_state;
                            addr_cnt <= nxt_start_addr;
                        end else if (elem.up) begin
                            addr_cnt <= addr_cnt + 1'b1;
                        end else begin
                            addr_cnt <= addr_cnt - 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
